// File: rtl/edge_detect_multi_if.sv
// rtl/edge_detect_multi_if.sv - channel bundle between pins/buttons and event consumers
interface edge_detect_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   level;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   evt_clr;
    logic [CH-1:0]   filt;
    logic [CH-1:0]   rise_tick;
    logic [CH-1:0]   fall_tick;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   evt_pending;
    logic            irq;

    modport master (
        output level, mode, evt_clr,
        input  filt, rise_tick, fall_tick, tick, evt_pending, irq
    );

    modport slave (
        input  level, mode, evt_clr,
        output filt, rise_tick, fall_tick, tick, evt_pending, irq
    );
endinterface

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel sync/debounce/edge-tick detector with sticky irq
module edge_detect_multi #(
    parameter int CH       = 4,
    parameter int SYNC     = 2,
    parameter int DEBOUNCE = 4
) (
    input logic               clk,
    input logic               rst_n,
    edge_detect_multi_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b10,
        FALL = 2'b11
    } state_t;

    logic [CH-1:0] filt_vec;
    logic [CH-1:0] rise_vec;
    logic [CH-1:0] fall_vec;
    logic [CH-1:0] tick_vec;
    logic [CH-1:0] pend_q;
    logic [CH-1:0] pend_d;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC-1:0] sync_q;
        logic            s;
        logic [CW-1:0]   cnt_q;
        logic [CW-1:0]   cnt_d;
        logic            filt_q;
        logic            filt_d;
        state_t          state_q;
        state_t          state_d;

        assign s = sync_q[SYNC-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                filt_q  <= 1'b0;
                state_q <= ZERO;
            end else begin
                sync_q  <= {sync_q[SYNC-2:0], bus.level[i]};
                cnt_q   <= cnt_d;
                filt_q  <= filt_d;
                state_q <= state_d;
            end
        end

        // Any cycle where s agrees with filt restarts the count from zero.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = '0;
            if (s != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_d = s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_comb begin
            state_d = ZERO;
            case (state_q)
                ZERO:    state_d = filt_q ? RISE : ZERO;
                RISE:    state_d = filt_q ? ONE  : FALL;
                ONE:     state_d = filt_q ? ONE  : FALL;
                FALL:    state_d = filt_q ? RISE : ZERO;
                default: state_d = ZERO;
            endcase
        end

        assign filt_vec[i] = filt_q;
        assign rise_vec[i] = (state_q == RISE);
        assign fall_vec[i] = (state_q == FALL);
        assign tick_vec[i] = (rise_vec[i] & bus.mode[2*i]) | (fall_vec[i] & bus.mode[2*i+1]);
    end

    // A new tick overrides a simultaneous clear.
    assign pend_d = (pend_q & ~bus.evt_clr) | tick_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.filt        = filt_vec;
    assign bus.rise_tick   = rise_vec;
    assign bus.fall_tick   = fall_vec;
    assign bus.tick        = tick_vec;
    assign bus.evt_pending = pend_q;
    assign bus.irq         = |pend_q;
endmodule
